// File: rtl/cache_line_fill_engine.sv
// cache_line_fill_engine: owns the AXI read channel for cache line fills.
// Takes one miss at a time, issues a single AR burst for the whole line,
// forwards each R beat to cache_4ways as a fill word, then reports done/error.
// Optional build macro CACHE_FILL_CRIT_WORD_FIRST_EN: WRAP burst starting at
// the missed word, so the critical word is filled first.
module cache_line_fill_engine #(
    parameter int         LINE_WORDS = 8,
    parameter logic [5:0] AXI_ID     = 6'h0
) (
    input  logic        cclk,
    input  logic        cresetn,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_addr,
    output logic        cm_arvalid,
    input  logic        cm_arready,
    output logic [5:0]  cm_arid,
    output logic [31:0] cm_araddr,
    output logic [3:0]  cm_arlen,
    output logic [2:0]  cm_arsize,
    output logic [1:0]  cm_arburst,
    input  logic        mc_rvalid,
    output logic        mc_rready,
    input  logic [31:0] mc_rdata,
    input  logic [5:0]  mc_rid,
    input  logic [1:0]  mc_rresp,
    input  logic        mc_rlast,
    output logic        fill_valid,
    input  logic        fill_ready,
    output logic [1:0]  fill_op,
    output logic [31:0] fill_addr,
    output logic [31:0] fill_data,
    output logic        fill_last,
    output logic        done_valid,
    output logic        done_err
);

    localparam int                BEAT_W    = $clog2(LINE_WORDS);
    localparam int                OFF_W     = $clog2(LINE_WORDS * 4);
    localparam logic [31:0]       LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [3:0]          arlen_q, arlen_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;       // word index within the line
    logic [BEAT_W-1:0]   cnt_q, cnt_d;         // beats received in this burst
    logic                err_q, err_d;
    logic                fill_valid_q, fill_valid_d;
    logic                fill_last_q, fill_last_d;
    logic [31:0]         fill_addr_q, fill_addr_d;
    logic [31:0]         fill_data_q, fill_data_d;
    logic                last_loaded_q, last_loaded_d;  // final forwarded word captured
    logic                need_rlast_q, need_rlast_d;    // dropping beats until rlast

    logic                rready;
    logic                final_beat;
    logic                beat_err;
    logic [31:0]         line_base;

    // Next-state, handshakes and output-register loads
    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        beat_d        = beat_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        fill_valid_d  = fill_valid_q;
        fill_last_d   = fill_last_q;
        fill_addr_d   = fill_addr_q;
        fill_data_d   = fill_data_q;
        last_loaded_d = last_loaded_q;
        need_rlast_d  = need_rlast_q;
        rready        = 1'b0;

        line_base  = araddr_q & LINE_MASK;
        final_beat = (cnt_q == LAST_BEAT) || mc_rlast;
        beat_err   = (mc_rresp != 2'b00) || (mc_rid != AXI_ID) ||
                     (mc_rlast && (cnt_q != LAST_BEAT)) ||
                     (!mc_rlast && (cnt_q == LAST_BEAT));

        unique case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
                    araddr_d = {miss_addr[31:2], 2'b00};
`else
                    araddr_d = miss_addr & LINE_MASK;
`endif
                    arlen_d  = 4'(LINE_WORDS - 1);
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (cm_arready) begin
                    state_d       = S_DATA;
                    cnt_d         = '0;
                    err_d         = 1'b0;
                    last_loaded_d = 1'b0;
                    need_rlast_d  = 1'b0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
                    beat_d        = araddr_q[OFF_W-1:2];
`else
                    beat_d        = '0;
`endif
                end
            end
            S_DATA: begin
                // Before the final word we accept only when the output slot
                // frees up; afterwards only to swallow surplus beats.
                if (!last_loaded_q) begin
                    rready = !fill_valid_q || fill_ready;
                end else begin
                    rready = need_rlast_q;
                end

                if (fill_valid_q && fill_ready) begin
                    fill_valid_d = 1'b0;
                    fill_last_d  = 1'b0;
                end

                if (rready && mc_rvalid) begin
                    if (!last_loaded_q) begin
                        fill_valid_d  = 1'b1;
                        fill_data_d   = mc_rdata;
                        fill_addr_d   = line_base + (32'(beat_q) << 2);
                        fill_last_d   = final_beat;
                        last_loaded_d = final_beat;
                        need_rlast_d  = (cnt_q == LAST_BEAT) && !mc_rlast;
                        err_d         = err_q || beat_err;
                        beat_d        = beat_q + BEAT_W'(1);
                        cnt_d         = cnt_q + BEAT_W'(1);
                    end else if (mc_rlast) begin
                        need_rlast_d  = 1'b0;
                    end
                end

                if (last_loaded_q && (!fill_valid_q || fill_ready) &&
                    (!need_rlast_q || (mc_rvalid && mc_rlast))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge cclk or negedge cresetn) begin
        if (!cresetn) begin
            state_q       <= S_IDLE;
            araddr_q      <= '0;
            arlen_q       <= '0;
            beat_q        <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            fill_valid_q  <= 1'b0;
            fill_last_q   <= 1'b0;
            fill_addr_q   <= '0;
            fill_data_q   <= '0;
            last_loaded_q <= 1'b0;
            need_rlast_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            beat_q        <= beat_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            fill_valid_q  <= fill_valid_d;
            fill_last_q   <= fill_last_d;
            fill_addr_q   <= fill_addr_d;
            fill_data_q   <= fill_data_d;
            last_loaded_q <= last_loaded_d;
            need_rlast_q  <= need_rlast_d;
        end
    end

    assign miss_ready = (state_q == S_IDLE);
    assign cm_arvalid = (state_q == S_AR);
    assign cm_arid    = AXI_ID;
    assign cm_araddr  = araddr_q;
    assign cm_arlen   = arlen_q;
    assign cm_arsize  = 3'b010;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    assign cm_arburst = 2'b10;
`else
    assign cm_arburst = 2'b01;
`endif
    assign mc_rready  = rready;
    assign fill_valid = fill_valid_q;
    assign fill_op    = 2'b11;
    assign fill_addr  = fill_addr_q;
    assign fill_data  = fill_data_q;
    assign fill_last  = fill_last_q;
    assign done_valid = (state_q == S_DONE);
    assign done_err   = (state_q == S_DONE) && err_q;

endmodule

// File: doc/cache_line_fill_engine.md
Name: cache_line_fill_engine

Overview:
Downstream of cache_controller's miss path; owns the AXI read channel to the memory controller.
- Accepts one line-fill request for a missed address.
- Issues a single AXI AR burst for the whole cache line.
- Collects the R beats and forwards each word to cache_4ways as a fill request (req_op 2'b11, req_last on the final word).
- Reports completion and error status back to the controller; one fill outstanding at a time.

Parameters:
LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16; cm_arlen = LINE_WORDS-1
AXI_ID, 6'h0, constant driven on cm_arid and expected on mc_rid

Ports:
cclk  in  1  cache clock; all logic on rising edge
cresetn  in  1  asynchronous active-low reset
miss_valid  in  1  fill request valid
miss_ready  out  1  high only in IDLE
miss_addr  in  32  byte address of missed access
cm_arvalid  out  1  AR valid
cm_arready  in  1  AR ready
cm_arid  out  6  = AXI_ID
cm_araddr  out  32  burst start address
cm_arlen  out  4  = LINE_WORDS-1
cm_arsize  out  3  = 3'b010
cm_arburst  out  2  2'b01 INCR (see optional feature)
mc_rvalid  in  1  R valid
mc_rready  out  1  R ready
mc_rdata  in  32  R data
mc_rid  in  6  R id
mc_rresp  in  2  R response
mc_rlast  in  1  R last
fill_valid  out  1  fill word valid to cache_4ways
fill_ready  in  1  cache accepts fill word
fill_op  out  2  constant 2'b11
fill_addr  out  32  word address of fill_data
fill_data  out  32  fill word
fill_last  out  1  final word of line
done_valid  out  1  one-cycle pulse, fill complete
done_err  out  1  valid with done_valid; any error during burst

Behaviour:
- Reset values: miss_ready=1, cm_arvalid=0, mc_rready=0, fill_valid=0, fill_last=0, done_valid=0, done_err=0. fill_addr and fill_data reset to 0. cm_araddr and cm_arlen are 0 until the first request. Internal state returns to IDLE, beat counter to 0.
- FSM: IDLE -> AR -> DATA -> DONE -> IDLE.
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch line base = miss_addr with low log2(LINE_WORDS*4) bits cleared; go to AR.
- AR:
  - cm_arvalid=1 from the cycle after acceptance; cm_araddr/cm_arlen are held stable.
  - On cm_arvalid&&cm_arready, go to DATA; clear beat counter and error flag.
- DATA:
  - Single-entry output register; mc_rready = !fill_valid || fill_ready.
  - On an R handshake, register fill_data = mc_rdata and fill_addr = base + 4*beat (beat wraps modulo LINE_WORDS).
  - fill_valid is set the next cycle: latency is 1 cycle from R handshake to fill_valid.
  - fill_last = 1 when the beat is the final one (beat == LINE_WORDS-1, or mc_rlast).
  - fill_valid clears on fill_ready unless a new beat is loaded in the same cycle; back-to-back beats give full throughput.
- Error flag (sticky per burst) is set by any of:
  - mc_rresp != 0;
  - mc_rid != AXI_ID;
  - mc_rlast before beat LINE_WORDS-1;
  - no mc_rlast on beat LINE_WORDS-1.
- Early rlast: that beat is forwarded with fill_last=1 and the burst ends.
- Missing rlast: beats after LINE_WORDS-1 are accepted (mc_rready=1) and dropped, not forwarded, until rlast.
- Burst end: leave DATA when the final forwarded word completes fill_ready, or when trailing dropped beats reach rlast, whichever is later.
- DONE:
  - done_valid=1 for exactly one cycle, done_err = error flag; return to IDLE.
  - A new miss may be accepted the following cycle.
- miss_valid outside IDLE is ignored (miss_ready=0).
- Reset mid-burst: all outputs return to reset values immediately. Outstanding R beats arriving after reset are not this block's concern; the memory controller shares the reset.

Optional Feature:
CACHE_FILL_CRIT_WORD_FIRST_EN
- Defined:
  - cm_arburst = 2'b10 (WRAP); cm_araddr = miss_addr word-aligned (low 2 bits cleared).
  - Beat counter starts at the requested word offset and wraps modulo LINE_WORDS, so the missed word is the first fill.
  - fill_last is still asserted on the LINE_WORDS-th beat.
- Undefined: cm_arburst = 2'b01 (INCR) from the line base; beat counter starts at 0.

Test Plan:
- Basic fill: miss_addr=32'h0000_1234, LINE_WORDS=8, fill_ready=1, eight R beats 0xA0..0xA7 with rlast on beat 7 and no gaps.
  -> cm_araddr=32'h0000_1220, cm_arlen=4'd7, cm_arsize=3'b010, cm_arburst=2'b01.
  -> fill_addr sequence 0x1220..0x123C; fill_last only with 0xA7.
  -> done_valid pulse with done_err=0.
- Backpressure: same burst with fill_ready toggling 1,0,0,1 repeatedly.
  -> mc_rready=0 whenever fill_valid && !fill_ready; no word lost or duplicated; order preserved.
- Error response: rresp=2'b10 on beat 3.
  -> all 8 words still forwarded; done_err=1.
- Early rlast: rlast on beat 4 with LINE_WORDS=8.
  -> 5 words forwarded, fill_last on the 5th; done_err=1.
- Reset mid-burst: cresetn low after beat 2 handshake.
  -> fill_valid=0, cm_arvalid=0, miss_ready=1 asynchronously; next miss_addr=32'h40 completes cleanly.
- With CACHE_FILL_CRIT_WORD_FIRST_EN: miss_addr=32'h0000_1234.
  -> cm_araddr=32'h0000_1234, cm_arburst=2'b10.
  -> fill_addr sequence 0x1234, 0x1238, 0x123C, 0x1220..0x1230; fill_last on 0x1230.
